seq_booth_mult: RTL



---
 rtl/seq_booth_mult_pkg.sv | 13 +
 rtl/seq_booth_mult_booth_step.sv | 31 +++
 rtl/seq_booth_mult.sv | 110 +++++++++++
 3 files changed

// File: rtl/seq_booth_mult_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package seq_booth_mult_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    // Booth pair {Q[0], q_-1} codes that require an add or a subtract.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/seq_booth_mult_booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of M into A,
// then arithmetic right shift of the combined {A, Q, q_-1} register.
module booth_step
    import seq_booth_mult_pkg::*;
#(
    parameter int N = 17
) (
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] q_in,
    input  logic         qm1_in,
    input  logic [N-1:0] m_in,
    output logic [N-1:0] a_out,
    output logic [N-1:0] q_out,
    output logic         qm1_out
);

    logic [N-1:0] a_sum;

    always_comb begin
        case ({q_in[0], qm1_in})
            BOOTH_ADD: a_sum = a_in + m_in;
            BOOTH_SUB: a_sum = a_in - m_in;
            default:   a_sum = a_in;
        endcase
        // The sign bit of A is replicated so the shift stays arithmetic.
        a_out   = {a_sum[N-1], a_sum[N-1:1]};
        q_out   = {a_sum[0], q_in[N-1:1]};
        qm1_out = q_in[0];
    end

endmodule

// File: rtl/seq_booth_mult.sv
// Parametrised sequential radix-2 Booth multiplier with start/busy/done
// handshake; one Booth step per clock, W+1 steps per product.
module seq_booth_mult
    import seq_booth_mult_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] p,
    output logic           busy,
    output logic           done
);

    localparam int N = W + 1;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    q_q, q_d;
    logic            qm1_q, qm1_d;
    logic [N-1:0]    m_q, m_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  p_q, p_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [N-1:0]    a_step, q_step;
    logic            qm1_step;

    booth_step #(.N(N)) u_step (
        .a_in    (a_q),
        .q_in    (q_q),
        .qm1_in  (qm1_q),
        .m_in    (m_q),
        .a_out   (a_step),
        .q_out   (q_step),
        .qm1_out (qm1_step)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Operands widen by one bit so unsigned values stay positive.
                    a_d     = '0;
                    q_d     = {sgn & y[W-1], y};
                    qm1_d   = 1'b0;
                    m_d     = {sgn & x[W-1], x};
                    cnt_d   = CW'(N);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                a_d   = a_step;
                q_d   = q_step;
                qm1_d = qm1_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    p_d     = {a_step[W-2:0], q_step};
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_CALC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign p    = p_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
